wb_trace_sink: RTL and testbench

WB_TRACE_SINK -- requirements
Module: wb_trace_sink

---
 rtl/wb_trace_sink.sv | 75 +++++++
 tb/tb_wb_trace_sink.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_trace_sink.sv
// wb_trace_sink: writeback trace FIFO with sequence tags and drop counter; WB_SHADOW_RF_EN adds a 32x16 shadow register file
module wb_trace_sink #(
    parameter int DEPTH = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       wbA_i,
    input  logic [4:0]                 wbAddrA_i,
    input  logic [15:0]                wbValA_i,
    output logic                       traceValid_o,
    input  logic                       traceReady_i,
    output logic [4:0]                 traceAddr_o,
    output logic [15:0]                traceVal_o,
    output logic [7:0]                 traceSeq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [7:0]                 dropCount_o,
    output logic                       overflow_o
`ifdef WB_SHADOW_RF_EN
    ,
    input  logic [4:0]                 rdAddr_i,
    output logic [15:0]                rdVal_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [28:0]   mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [7:0]    seq;
    logic          pop, push, drop;
    always_comb begin
        empty_o = count_o == '0;
        full_o = count_o == CW'(DEPTH);
        traceValid_o = !empty_o;
        pop = traceValid_o && traceReady_i;
        push = wbA_i && (!full_o || pop);
        drop = wbA_i && full_o && !pop;
        {traceSeq_o, traceAddr_o, traceVal_o} = empty_o ? 29'd0 : mem[rdPtr];
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count_o <= '0;
            seq <= '0;
            dropCount_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wbA_i) seq <= seq + 8'd1;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) rdPtr <= rdPtr + AW'(1);
            count_o <= count_o + CW'(push) - CW'(pop);
            if (drop) begin
                dropCount_o <= dropCount_o + 8'(dropCount_o != 8'hff);
                overflow_o <= 1'b1;
            end
        end
    end
    // Stale slots are masked by empty_o, so storage needs no reset.
    always_ff @(posedge clock_i) begin
        if (push) mem[wrPtr] <= {seq, wbAddrA_i, wbValA_i};
    end
`ifdef WB_SHADOW_RF_EN
    logic [15:0] shadow [32];
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (wbA_i) begin
            shadow[wbAddrA_i] <= wbValA_i;
        end
    end
    assign rdVal_o = shadow[rdAddr_i];
`endif
endmodule

// File: tb/tb_wb_trace_sink.sv
// tb_wb_trace_sink: randomized and directed checks of wb_trace_sink against a queue model
module tb_wb_trace_sink;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;
    logic clock_i = 0, reset_i = 1, wbA_i = 0, traceReady_i = 0;
    logic [4:0] wbAddrA_i = 0;
    logic [15:0] wbValA_i = 0;
    logic traceValid_o, full_o, empty_o, overflow_o;
    logic [4:0] traceAddr_o;
    logic [15:0] traceVal_o;
    logic [7:0] traceSeq_o, dropCount_o;
    logic [CW-1:0] count_o;
`ifdef WB_SHADOW_RF_EN
    logic [4:0] rdAddr_i = 0;
    logic [15:0] rdVal_o;
    logic [15:0] shadowM [32];
`endif
    int compared = 0, mismatched = 0;
    logic [28:0] q[$];
    logic [7:0] seqM = 0, dropM = 0;
    logic ovM = 0;

    wb_trace_sink #(.DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .wbA_i(wbA_i), .wbAddrA_i(wbAddrA_i),
        .wbValA_i(wbValA_i), .traceValid_o(traceValid_o), .traceReady_i(traceReady_i),
        .traceAddr_o(traceAddr_o), .traceVal_o(traceVal_o), .traceSeq_o(traceSeq_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .dropCount_o(dropCount_o),
        .overflow_o(overflow_o)
`ifdef WB_SHADOW_RF_EN
        , .rdAddr_i(rdAddr_i), .rdVal_o(rdVal_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic verify();
        check("valid", 32'(traceValid_o), 32'(q.size() != 0));
        check("count", 32'(count_o), q.size());
        check("full", 32'(full_o), 32'(q.size() == DEPTH));
        check("empty", 32'(empty_o), 32'(q.size() == 0));
        check("dropCount", 32'(dropCount_o), 32'(dropM));
        check("overflow", 32'(overflow_o), 32'(ovM));
        if (q.size() != 0) begin
            check("headSeq", 32'(traceSeq_o), 32'(q[0][28:21]));
            check("headAddr", 32'(traceAddr_o), 32'(q[0][20:16]));
            check("headVal", 32'(traceVal_o), 32'(q[0][15:0]));
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [15:0] v, input logic rdy);
        bit pop;
        reset_i = r; wbA_i = w; wbAddrA_i = a; wbValA_i = v; traceReady_i = rdy;
`ifdef WB_SHADOW_RF_EN
        #1 check("rdVal", 32'(rdVal_o), 32'(shadowM[rdAddr_i]));
`endif
        @(posedge clock_i);
        if (r) begin
            q.delete(); seqM = 0; dropM = 0; ovM = 0;
`ifdef WB_SHADOW_RF_EN
            for (int i = 0; i < 32; i++) shadowM[i] = 0;
`endif
        end else begin
            pop = q.size() != 0 && rdy;
            if (pop) void'(q.pop_front());
            if (w) begin
                if (q.size() < DEPTH) q.push_back({seqM, a, v});
                else begin
                    if (dropM != 8'hff) dropM++;
                    ovM = 1;
                end
                seqM++;
`ifdef WB_SHADOW_RF_EN
                shadowM[a] = v;
`endif
            end
        end
        #1 verify();
    endtask

    task automatic headZero();
        check("rstAddr", 32'(traceAddr_o), 0);
        check("rstVal", 32'(traceVal_o), 0);
        check("rstSeq", 32'(traceSeq_o), 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        headZero();
        // single event, held while not ready
        step(0, 1, 5'd3, 16'h1234, 0);
        check("evAddr", 32'(traceAddr_o), 3);
        check("evVal", 32'(traceVal_o), 32'h1234);
        check("evSeq", 32'(traceSeq_o), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check("holdVal", 32'(traceVal_o), 32'h1234);
        // overflow by one
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 5'(i), 16'(16'h100 + i), 0);
        check("fullFlag", 32'(full_o), 1);
        check("fullDrop", 32'(dropCount_o), 1);
        check("fullOvf", 32'(overflow_o), 1);
        check("fullHeadSeq", 32'(traceSeq_o), 0);
        // push and pop on full
        step(0, 1, 5'd30, 16'hcafe, 1);
        check("pushPopCount", 32'(count_o), DEPTH);
        check("pushPopDrop", 32'(dropCount_o), 1);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 1);
        // long run with ready held high
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 5'($urandom), 16'($urandom), 1);
        check("wrapSeq", 32'(traceSeq_o), 32'(299 % 256));
        check("wrapDrop", 32'(dropCount_o), 0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
`ifdef WB_SHADOW_RF_EN
            rdAddr_i = 5'($urandom);
`endif
            step(0, 1'($urandom_range(0, 3) != 0), 5'($urandom), 16'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        // reset mid-stream with coincident event
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 5'($urandom), 16'($urandom), 0);
        step(1, 1, 5'd9, 16'h5555, 1);
        check("rstEmpty", 32'(empty_o), 1);
        check("rstCount", 32'(count_o), 0);
        headZero();
        step(0, 1, 5'd4, 16'h4444, 0);
        check("rstSeqRestart", 32'(traceSeq_o), 0);
`ifdef WB_SHADOW_RF_EN
        step(1, 0, 0, 0, 0);
        rdAddr_i = 5'd7;
        step(0, 1, 5'd7, 16'hbeef, 0);
        check("shadowNext", 32'(rdVal_o), 32'hbeef);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
